// File: rtl/writeback_regfile.sv
// Writeback stage register feeding a 16x32 ARM register file and the PC; capture at edge N, commit at N+1.
// Reads bypass the pending entry (r15 reads pc+PC_READ); stall holds stage, register file and PC.
module writeback_regfile #(
    parameter int unsigned              DATA_W   = 32,
    parameter logic [DATA_W-1:0]        PC_RESET = '0,
    parameter int unsigned              PC_STEP  = 4,
    parameter int unsigned              PC_READ  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              wb_en,
    input  logic              wb_is_branch,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] pc,
    output logic              wb_pending
);

    logic              valid_q, valid_d;
    logic              branch_q, branch_d;
    logic [3:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [15];
    logic [DATA_W-1:0] regs_d [15];

    always_comb begin
        valid_d  = valid_q;
        branch_d = branch_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pc_d     = pc_q;
        regs_d   = regs_q;
        if (!stall) begin
            valid_d  = wb_en;
            branch_d = wb_is_branch;
            addr_d   = wb_addr;
            data_d   = wb_data;
            pc_d     = pc_q + DATA_W'(PC_STEP);
            if (valid_q) begin
                // Branch targets and r15 writes both land in the PC, word aligned.
                if (branch_q || addr_q == 4'd15)
                    pc_d = {data_q[DATA_W-1:2], 2'b00};
                else
                    regs_d[addr_q] = data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            branch_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            pc_q     <= PC_RESET;
            for (int i = 0; i < 15; i++)
                regs_q[i] <= '0;
        end else begin
            valid_q  <= valid_d;
            branch_q <= branch_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pc_q     <= pc_d;
            regs_q   <= regs_d;
        end
    end

    // r15 never bypasses; a pending branch is not a GPR write so it never bypasses either.
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (a == 4'd15)
            r = pc_q + DATA_W'(PC_READ);
        else if (valid_q && !branch_q && addr_q == a)
            r = data_q;
        else
            r = regs_q[a];
        return r;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    assign pc         = pc_q;
    assign wb_pending = valid_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: hand-computed PC trace across all scenarios.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        wb_en = 1'b0;
    logic        wb_is_branch = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b, pc;
    logic        wb_pending;

    int checks = 0;
    int failures = 0;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .wb_en(wb_en),
        .wb_is_branch(wb_is_branch), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pc(pc), .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] a, input logic [3:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    task automatic drive(input logic en, input logic br, input logic [3:0] addr, input logic [31:0] data);
        wb_en = en;
        wb_is_branch = br;
        wb_addr = addr;
        wb_data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        set_rd(4'd3, 4'd3);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL reset_r3 got=%h exp=%h", rd_data_a, 32'h0); end
        checks++; if (wb_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", wb_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step(); step();
        checks++; if (pc !== 32'd12) begin failures++; $display("FAIL reset_pc_step got=%h exp=%h", pc, 32'd12); end
    endtask

    task automatic test_write();
        drive(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        set_rd(4'd3, 4'd3);
        checks++; if (wb_pending !== 1'b1) begin failures++; $display("FAIL write_pending got=%b exp=1", wb_pending); end
        checks++; if (rd_data_a !== 32'hDEADBEEF) begin failures++; $display("FAIL write_bypass_a got=%h exp=%h", rd_data_a, 32'hDEADBEEF); end
        checks++; if (rd_data_b !== 32'hDEADBEEF) begin failures++; $display("FAIL write_bypass_b got=%h exp=%h", rd_data_b, 32'hDEADBEEF); end
        checks++; if (pc !== 32'd16) begin failures++; $display("FAIL write_pc1 got=%h exp=%h", pc, 32'd16); end
        step();
        checks++; if (wb_pending !== 1'b0) begin failures++; $display("FAIL write_pending_clr got=%b exp=0", wb_pending); end
        checks++; if (rd_data_a !== 32'hDEADBEEF) begin failures++; $display("FAIL write_commit got=%h exp=%h", rd_data_a, 32'hDEADBEEF); end
        checks++; if (pc !== 32'd20) begin failures++; $display("FAIL write_pc2 got=%h exp=%h", pc, 32'd20); end
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b1, 4'd5, 32'h103);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        set_rd(4'd5, 4'd15);
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL branch_no_bypass got=%h exp=%h", rd_data_a, 32'h0); end
        checks++; if (pc !== 32'd24) begin failures++; $display("FAIL branch_pc1 got=%h exp=%h", pc, 32'd24); end
        step();
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h100); end
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL branch_r5 got=%h exp=%h", rd_data_a, 32'h0); end
        checks++; if (rd_data_b !== 32'h108) begin failures++; $display("FAIL branch_r15 got=%h exp=%h", rd_data_b, 32'h108); end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 4'd7, 32'h55);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        stall = 1'b1;
        set_rd(4'd7, 4'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h104) begin failures++; $display("FAIL stall_pc_%0d got=%h exp=%h", i, pc, 32'h104); end
            checks++; if (wb_pending !== 1'b1) begin failures++; $display("FAIL stall_pending_%0d got=%b exp=1", i, wb_pending); end
            checks++; if (rd_data_a !== 32'h55) begin failures++; $display("FAIL stall_bypass_%0d got=%h exp=%h", i, rd_data_a, 32'h55); end
        end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h108) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", pc, 32'h108); end
        checks++; if (wb_pending !== 1'b0) begin failures++; $display("FAIL stall_release_pending got=%b exp=0", wb_pending); end
        checks++; if (rd_data_b !== 32'h55) begin failures++; $display("FAIL stall_commit got=%h exp=%h", rd_data_b, 32'h55); end
    endtask

    task automatic test_no_enable();
        drive(1'b0, 1'b0, 4'd2, 32'hFF);
        set_rd(4'd2, 4'd2);
        step();
        checks++; if (wb_pending !== 1'b0) begin failures++; $display("FAIL noen_pending got=%b exp=0", wb_pending); end
        checks++; if (pc !== 32'h10C) begin failures++; $display("FAIL noen_pc1 got=%h exp=%h", pc, 32'h10C); end
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL noen_r2 got=%h exp=%h", rd_data_a, 32'h0); end
        checks++; if (pc !== 32'h110) begin failures++; $display("FAIL noen_pc2 got=%h exp=%h", pc, 32'h110); end
    endtask

    task automatic test_back_to_back();
        set_rd(4'd9, 4'd9);
        drive(1'b1, 1'b0, 4'd9, 32'h11);
        step();
        checks++; if (rd_data_a !== 32'h11) begin failures++; $display("FAIL b2b_first got=%h exp=%h", rd_data_a, 32'h11); end
        drive(1'b1, 1'b0, 4'd9, 32'h22);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (rd_data_a !== 32'h22) begin failures++; $display("FAIL b2b_youngest_a got=%h exp=%h", rd_data_a, 32'h22); end
        checks++; if (rd_data_b !== 32'h22) begin failures++; $display("FAIL b2b_youngest_b got=%h exp=%h", rd_data_b, 32'h22); end
        checks++; if (pc !== 32'h118) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", pc, 32'h118); end
        step();
        checks++; if (rd_data_a !== 32'h22) begin failures++; $display("FAIL b2b_commit got=%h exp=%h", rd_data_a, 32'h22); end
        checks++; if (pc !== 32'h11C) begin failures++; $display("FAIL b2b_pc2 got=%h exp=%h", pc, 32'h11C); end
    endtask

    task automatic test_pc_write();
        set_rd(4'd15, 4'd15);
        drive(1'b1, 1'b0, 4'd15, 32'h2002);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (rd_data_a !== 32'h128) begin failures++; $display("FAIL pcw_no_bypass got=%h exp=%h", rd_data_a, 32'h128); end
        step();
        checks++; if (pc !== 32'h2000) begin failures++; $display("FAIL pcw_pc got=%h exp=%h", pc, 32'h2000); end
        checks++; if (rd_data_b !== 32'h2008) begin failures++; $display("FAIL pcw_r15 got=%h exp=%h", rd_data_b, 32'h2008); end
    endtask

    task automatic test_async_reset();
        set_rd(4'd4, 4'd3);
        drive(1'b1, 1'b0, 4'd4, 32'h1);
        step();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (wb_pending !== 1'b1) begin failures++; $display("FAIL areset_pre_pending got=%b exp=1", wb_pending); end
        checks++; if (pc !== 32'h2004) begin failures++; $display("FAIL areset_pre_pc got=%h exp=%h", pc, 32'h2004); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL areset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (wb_pending !== 1'b0) begin failures++; $display("FAIL areset_pending got=%b exp=0", wb_pending); end
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL areset_r4 got=%h exp=%h", rd_data_a, 32'h0); end
        checks++; if (rd_data_b !== 32'h0) begin failures++; $display("FAIL areset_r3 got=%h exp=%h", rd_data_b, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (pc !== 32'd4) begin failures++; $display("FAIL areset_restart_pc got=%h exp=%h", pc, 32'd4); end
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL areset_r4_after got=%h exp=%h", rd_data_a, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_branch();
        test_stall();
        test_no_enable();
        test_back_to_back();
        test_pc_write();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
